light_monitor: RTL and testbench
================================

Name: light_monitor

Overview:
- Receiving end of the traffic-light colour bus: consumes the 2-bit colour code (red=2'b00, yellow=2'b01, green=2'b10; 2'b11 unnamed/illegal) that a light controller emits.
- Drives one-hot lamp outputs from the code.
- Checks the controller's sequence order and minimum dwell times.
- On any violation, latches a sticky fault and forces flashing yellow until it is cleared.

Parameters:
- MIN_GREEN, 8, minimum consecutive cycles green must be held before leaving it (1..65535)
- MIN_YELLOW, 3, minimum cycles for yellow (1..65535)
- MIN_RED, 6, minimum cycles for red (1..65535)
- BLINK_PERIOD, 4, cycles per half-period of the fault yellow flash (1..65535)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- light_in  input  2  colour code from controller (colors encoding)
- clear  input  1  one-cycle pulse; clears a latched fault
- lamp_r  output  1  red lamp drive
- lamp_y  output  1  yellow lamp drive
- lamp_g  output  1  green lamp drive
- fault  output  1  sticky violation flag
- fault_code  output  2  0=none, 1=illegal code 2'b11, 2=bad order, 3=dwell too short
- cycle_cnt  output  8  count of completed green->yellow->red->green cycles, wraps 255->0

Behaviour:
- Reset is synchronous and active-high, on the single clock clk. On reset:
  - State goes to INIT.
  - All lamps are 0, fault=0, fault_code=0, cycle_cnt=0.
  - The dwell counter is 0 and the blink phase is 0.
- All outputs are registered. light_in is sampled at edge k, and its effect is visible on the outputs immediately after edge k (one-edge latency, no extra pipeline stage).
- Dwell counter:
  - 16-bit, counts consecutive edges at which the sampled colour equals the current colour.
  - Set to 1 on the first sample of a new colour.
  - Saturates at 65535.
- State INIT (no current colour yet):
  - light_in legal: that colour becomes current, dwell=1, matching lamp=1, go to TRACK. Any colour is an acceptable starting point; there is no order check.
  - light_in = 2'b11: go to FAULT with fault_code=1.
- State TRACK:
  - light_in == current: dwell++ (saturating); lamps unchanged.
  - light_in = 2'b11: FAULT, code 1.
  - light_in differs and is not the legal successor: FAULT, code 2. The only legal successors are green->yellow, yellow->red, red->green.
  - Legal successor but old dwell < MIN_x of the old colour: FAULT, code 3.
  - Legal successor and old dwell >= MIN_x: current = new colour, dwell=1, lamps switch one-hot to the new colour.
  - On a legal red->green transition, cycle_cnt increments, wrapping at 8 bits. The first red->green after INIT also counts.
- Error priority when several conditions hold in one sample: code 1 > code 2 > code 3.
- State FAULT:
  - Entry:
    - fault=1, fault_code latched.
    - lamp_r=0, lamp_g=0, lamp_y=1.
    - Blink counter = 0.
  - Every edge the blink counter increments. When it reaches BLINK_PERIOD-1, lamp_y toggles and the counter returns to 0.
  - With BLINK_PERIOD=1, lamp_y toggles every edge.
  - light_in is ignored while in FAULT.
  - cycle_cnt holds its value.
  - fault_code does not change on further violations.
- clear:
  - In FAULT: next state INIT; fault=0, fault_code=0, all lamps 0, dwell=0. cycle_cnt is preserved. The light_in sample taken at that edge is discarded, and INIT evaluates from the next edge.
  - Outside FAULT: clear has no effect.
- Priority: reset > clear > violation detection.
- reset mid-operation, any state: returns to INIT with all reset values, including cycle_cnt=0.
- Exactly one of lamp_r/lamp_y/lamp_g is 1 in TRACK. In INIT all are 0. In FAULT only lamp_y can be 1.

Test Plan:
- Bench parameters for all scenarios: MIN_GREEN=4, MIN_YELLOW=2, MIN_RED=3, BLINK_PERIOD=2.
- Legal sequence: reset, then green x4, yellow x2, red x3, green x1.
  -> Lamps track one edge after each sample, g->y->r->g.
  -> fault stays 0.
  -> cycle_cnt = 1 after the final green sample.
- Short dwell: green x3 then yellow.
  -> At the yellow sample edge: fault=1, fault_code=3, lamp_g=0, lamp_y=1.
  -> lamp_y then reads 1,1,0,0,1,1... (toggling every 2 edges).
- Bad order and illegal code:
  - green x4 then red -> fault_code=2.
  - After clear, in INIT apply 2'b11 -> fault_code=1, lamps r=g=0.
- Clear priority: in FAULT, assert clear for one cycle while light_in = 2'b11.
  -> Next edge: state INIT, fault=0, fault_code=0, all lamps 0; the 2'b11 is discarded.
  -> cycle_cnt is unchanged from its value before clear.
- Saturation and wrap:
  - Hold red for 70000 cycles, then green -> accepted, no fault (dwell saturates at 65535, no wrap to a short value).
  - Run 256 legal cycles -> cycle_cnt wraps to 0.
- Mid-operation reset: assert reset during FAULT with cycle_cnt=5.
  -> Next edge all outputs 0.
  -> The first subsequent legal sample enters TRACK normally.

Source files
------------

// File: rtl/light_monitor.sv
// Receiver for the traffic-light colour bus. It drives one-hot lamps, checks the
// sequence order and dwell times, and latches a sticky fault that flashes yellow.
module light_monitor #(
    parameter int unsigned MIN_GREEN    = 8,
    parameter int unsigned MIN_YELLOW   = 3,
    parameter int unsigned MIN_RED      = 6,
    parameter int unsigned BLINK_PERIOD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] light_in,
    input  logic       clear,
    output logic       lamp_r,
    output logic       lamp_y,
    output logic       lamp_g,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [7:0] cycle_cnt
);

    localparam logic [1:0] Red     = 2'b00;
    localparam logic [1:0] Yellow  = 2'b01;
    localparam logic [1:0] Green   = 2'b10;
    localparam logic [1:0] Illegal = 2'b11;

    localparam logic [15:0] MinGreen  = 16'(MIN_GREEN);
    localparam logic [15:0] MinYellow = 16'(MIN_YELLOW);
    localparam logic [15:0] MinRed    = 16'(MIN_RED);
    localparam logic [15:0] BlinkLast = 16'(BLINK_PERIOD - 1);

    localparam logic [1:0] CodeIllegal = 2'd1;
    localparam logic [1:0] CodeOrder   = 2'd2;
    localparam logic [1:0] CodeDwell   = 2'd3;

    typedef enum logic [1:0] {StInit, StTrack, StFault} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cur_q, cur_d;
    logic [15:0] dwell_q, dwell_d;
    logic [15:0] blink_q, blink_d;
    logic [2:0]  lamps_q, lamps_d;  // {r, y, g}
    logic        fault_q, fault_d;
    logic [1:0]  code_q, code_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        enter;
    logic [1:0]  enter_code;

    function automatic logic [1:0] successor(input logic [1:0] c);
        case (c)
            Green:   successor = Yellow;
            Yellow:  successor = Red;
            Red:     successor = Green;
            default: successor = Illegal;
        endcase
    endfunction

    function automatic logic [15:0] min_dwell(input logic [1:0] c);
        case (c)
            Green:   min_dwell = MinGreen;
            Yellow:  min_dwell = MinYellow;
            default: min_dwell = MinRed;
        endcase
    endfunction

    function automatic logic [2:0] one_hot(input logic [1:0] c);
        case (c)
            Red:     one_hot = 3'b100;
            Yellow:  one_hot = 3'b010;
            Green:   one_hot = 3'b001;
            default: one_hot = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StInit;
            cur_q   <= Red;
            dwell_q <= '0;
            blink_q <= '0;
            lamps_q <= '0;
            fault_q <= 1'b0;
            code_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            dwell_q <= dwell_d;
            blink_q <= blink_d;
            lamps_q <= lamps_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        dwell_d    = dwell_q;
        blink_d    = blink_q;
        lamps_d    = lamps_q;
        fault_d    = fault_q;
        code_d     = code_q;
        cnt_d      = cnt_q;
        enter      = 1'b0;
        enter_code = '0;

        unique case (state_q)
            StInit: begin
                if (light_in == Illegal) begin
                    enter      = 1'b1;
                    enter_code = CodeIllegal;
                end else begin
                    state_d = StTrack;
                    cur_d   = light_in;
                    dwell_d = 16'd1;
                    lamps_d = one_hot(light_in);
                end
            end
            StTrack: begin
                if (light_in == cur_q) begin
                    if (dwell_q != 16'hffff) dwell_d = dwell_q + 16'd1;
                end else if (light_in == Illegal) begin
                    enter      = 1'b1;
                    enter_code = CodeIllegal;
                end else if (light_in != successor(cur_q)) begin
                    enter      = 1'b1;
                    enter_code = CodeOrder;
                end else if (dwell_q < min_dwell(cur_q)) begin
                    enter      = 1'b1;
                    enter_code = CodeDwell;
                end else begin
                    cur_d   = light_in;
                    dwell_d = 16'd1;
                    lamps_d = one_hot(light_in);
                    if (cur_q == Red) cnt_d = cnt_q + 8'd1;
                end
            end
            StFault: begin
                // The sample taken with clear is dropped; INIT looks from the next edge.
                if (clear) begin
                    state_d = StInit;
                    fault_d = 1'b0;
                    code_d  = '0;
                    lamps_d = '0;
                    dwell_d = '0;
                    blink_d = '0;
                end else if (blink_q == BlinkLast) begin
                    blink_d    = '0;
                    lamps_d[1] = ~lamps_q[1];
                end else begin
                    blink_d = blink_q + 16'd1;
                end
            end
            default: state_d = StInit;
        endcase

        if (enter) begin
            state_d = StFault;
            fault_d = 1'b1;
            code_d  = enter_code;
            lamps_d = 3'b010;
            blink_d = '0;
        end
    end

    always_comb begin
        lamp_r     = lamps_q[2];
        lamp_y     = lamps_q[1];
        lamp_g     = lamps_q[0];
        fault      = fault_q;
        fault_code = code_q;
        cycle_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_light_monitor.sv
// Directed bench for light_monitor: each task drives one scenario and checks the
// packed output word {r, y, g, fault, fault_code, cycle_cnt} against hand values.
module tb_light_monitor;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] G = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] light_in = 2'b00;
    logic       clear = 1'b0;
    logic       lamp_r, lamp_y, lamp_g, fault;
    logic [1:0] fault_code;
    logic [7:0] cycle_cnt;
    logic [13:0] obs;
    logic [13:0] exp;
    int checks = 0;
    int errors = 0;

    light_monitor #(
        .MIN_GREEN   (4),
        .MIN_YELLOW  (2),
        .MIN_RED     (3),
        .BLINK_PERIOD(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .light_in  (light_in),
        .clear     (clear),
        .lamp_r    (lamp_r),
        .lamp_y    (lamp_y),
        .lamp_g    (lamp_g),
        .fault     (fault),
        .fault_code(fault_code),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {lamp_r, lamp_y, lamp_g, fault, fault_code, cycle_cnt};

    task automatic apply(input logic [1:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            light_in = c;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear = 1'b0;
        apply(R, 1);
        reset = 1'b0;
    endtask

    // One full legal cycle starting from green with enough dwell: y2 r3 g4.
    task automatic legal_cycle();
        apply(Y, 2);
        apply(R, 3);
        apply(G, 4);
    endtask

    task automatic test_reset();
        do_reset();
        exp = 14'd0;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_init obs=%h exp=%h", obs, exp); end
        apply(G, 1);
        exp = {3'b001, 1'b0, 2'd0, 8'd0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_first obs=%h exp=%h", obs, exp); end
        do_reset();
        exp = 14'd0;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_track obs=%h exp=%h", obs, exp); end
    endtask

    task automatic test_legal();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(G, 1);
            exp = {3'b001, 1'b0, 2'd0, 8'd0};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL legal_g%0d obs=%h exp=%h", i, obs, exp); end
        end
        for (int i = 0; i < 2; i++) begin
            apply(Y, 1);
            exp = {3'b010, 1'b0, 2'd0, 8'd0};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL legal_y%0d obs=%h exp=%h", i, obs, exp); end
        end
        for (int i = 0; i < 3; i++) begin
            apply(R, 1);
            exp = {3'b100, 1'b0, 2'd0, 8'd0};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL legal_r%0d obs=%h exp=%h", i, obs, exp); end
        end
        apply(G, 1);
        exp = {3'b001, 1'b0, 2'd0, 8'd1};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL legal_wrap_g obs=%h exp=%h", obs, exp); end
        clear = 1'b1;
        apply(G, 1);
        clear = 1'b0;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL clear_in_track obs=%h exp=%h", obs, exp); end
    endtask

    task automatic test_short_dwell();
        logic [4:0] ypat;
        ypat = 5'b10011;  // lamp_y on edges 1..5 after fault entry, MSB first
        do_reset();
        apply(G, 3);
        apply(Y, 1);
        exp = {3'b010, 1'b1, 2'd3, 8'd0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL short_dwell obs=%h exp=%h", obs, exp); end
        for (int k = 0; k < 5; k++) begin
            apply(G, 1);
            exp = {1'b0, ypat[4-k], 1'b0, 1'b1, 2'd3, 8'd0};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL blink%0d obs=%h exp=%h", k, obs, exp); end
        end
    endtask

    task automatic test_bad_order();
        do_reset();
        apply(G, 4);
        apply(R, 1);
        exp = {3'b010, 1'b1, 2'd2, 8'd0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL bad_order obs=%h exp=%h", obs, exp); end
        clear = 1'b1;
        apply(G, 1);
        clear = 1'b0;
        exp = 14'd0;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL order_clear obs=%h exp=%h", obs, exp); end
        apply(X, 1);
        exp = {3'b010, 1'b1, 2'd1, 8'd0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL illegal_init obs=%h exp=%h", obs, exp); end
        apply(R, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL code_sticky obs=%h exp=%h", obs, exp); end
    endtask

    task automatic test_clear_priority();
        do_reset();
        apply(G, 4);
        apply(Y, 2);
        apply(R, 3);
        apply(G, 1);
        apply(X, 1);
        exp = {3'b010, 1'b1, 2'd1, 8'd1};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL illegal_track obs=%h exp=%h", obs, exp); end
        clear = 1'b1;
        apply(X, 1);
        clear = 1'b0;
        exp = {3'b000, 1'b0, 2'd0, 8'd1};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL clear_prio obs=%h exp=%h", obs, exp); end
        apply(Y, 1);
        exp = {3'b010, 1'b0, 2'd0, 8'd1};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL post_clear obs=%h exp=%h", obs, exp); end
    endtask

    task automatic test_saturation();
        do_reset();
        // One past 2^16: a wrapping dwell would read 1 here and trip the red minimum.
        apply(R, 65537);
        exp = {3'b100, 1'b0, 2'd0, 8'd0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL long_red obs=%h exp=%h", obs, exp); end
        apply(G, 1);
        exp = {3'b001, 1'b0, 2'd0, 8'd1};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sat_exit obs=%h exp=%h", obs, exp); end
    endtask

    task automatic test_wrap();
        do_reset();
        apply(G, 4);
        for (int i = 0; i < 256; i++) begin
            legal_cycle();
            if (i == 254) begin
                exp = {3'b001, 1'b0, 2'd0, 8'd255};
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL cnt_255 obs=%h exp=%h", obs, exp); end
            end
        end
        exp = {3'b001, 1'b0, 2'd0, 8'd0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL cnt_wrap obs=%h exp=%h", obs, exp); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        apply(G, 4);
        for (int i = 0; i < 5; i++) legal_cycle();
        exp = {3'b001, 1'b0, 2'd0, 8'd5};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL cnt_5 obs=%h exp=%h", obs, exp); end
        apply(X, 1);
        exp = {3'b010, 1'b1, 2'd1, 8'd5};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL fault_cnt5 obs=%h exp=%h", obs, exp); end
        reset = 1'b1;
        apply(G, 1);
        reset = 1'b0;
        exp = 14'd0;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL mid_reset obs=%h exp=%h", obs, exp); end
        apply(Y, 1);
        exp = {3'b010, 1'b0, 2'd0, 8'd0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL after_reset obs=%h exp=%h", obs, exp); end
    endtask

    initial begin
        #1;
        test_reset();
        test_legal();
        test_short_dwell();
        test_bad_order();
        test_clear_priority();
        test_saturation();
        test_wrap();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
